// File: rtl/pipe_skid_stage_if.sv
// Valid/ready bundle carrying one pipeline entry (data + control) between stages.
// A transfer happens on a rising clk edge where valid and ready are both 1; the
// master holds valid, data and ctrl stable until that edge, and ready never waits on valid.
interface pipe_skid_if #(
  parameter int DATA_W = 48,
  parameter int CTRL_W = 14
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input ready);
  modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_skid_stage.sv
// Parametrised pipeline stage register with a head/skid pair, registered in_ready,
// synchronous flush and control masking so bubbles never fire stage strobes.
module pipe_skid_stage #(
  parameter int                DATA_W     = 48,
  parameter int                CTRL_W     = 14,
  parameter logic [CTRL_W-1:0] CTRL_RESET = {CTRL_W{1'b0}}
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  pipe_skid_if.slave  in_if,
  pipe_skid_if.master out_if,
  output logic [1:0]  occupancy,
  output logic [1:0]  dbg_state
);

  // State is exactly {s_valid, h_valid}; 2'b10 cannot be reached.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

  logic              h_valid;
  logic              s_valid;
  logic [DATA_W-1:0] h_data;
  logic [DATA_W-1:0] s_data;
  logic [CTRL_W-1:0] h_ctrl;
  logic [CTRL_W-1:0] s_ctrl;
  logic [1:0]        state;
  logic              accept;
  logic              pop;

  assign state  = {s_valid, h_valid};
  assign accept = in_if.valid & in_if.ready;
  assign pop    = out_if.valid & out_if.ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_valid <= 1'b0;
      s_valid <= 1'b0;
      h_data  <= '0;
      s_data  <= '0;
      h_ctrl  <= CTRL_RESET;
      s_ctrl  <= CTRL_RESET;
    end else if (flush) begin
      // Squash: control goes safe, data is left untouched.
      h_valid <= 1'b0;
      s_valid <= 1'b0;
      h_ctrl  <= CTRL_RESET;
      s_ctrl  <= CTRL_RESET;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            h_valid <= 1'b1;
            h_data  <= in_if.data;
            h_ctrl  <= in_if.ctrl;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            h_data <= in_if.data;
            h_ctrl <= in_if.ctrl;
          end else if (accept) begin
            s_valid <= 1'b1;
            s_data  <= in_if.data;
            s_ctrl  <= in_if.ctrl;
          end else if (pop) begin
            h_valid <= 1'b0;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only a pop can move things.
          if (pop) begin
            h_data  <= s_data;
            h_ctrl  <= s_ctrl;
            s_valid <= 1'b0;
          end
        end
        default: begin
          h_valid <= 1'b0;
          s_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_if.ready  = ~s_valid;
  assign out_if.valid = h_valid;
  assign out_if.data  = h_data;
  assign out_if.ctrl  = h_valid ? h_ctrl : CTRL_RESET;
  assign occupancy    = {1'b0, h_valid} + {1'b0, s_valid};
  assign dbg_state    = state;

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Generic, parametrised pipeline stage register; replaces fixed per-stage buffers (IF/ID, ID/EX, EX/MEM, MEM/WB) in the 16-bit core.
- Carries a data bundle and a control bundle between stages with valid/ready flow control, stall absorption via a 2-entry skid buffer, and synchronous flush for branch/exception squash.
- Control fields presented downstream are forced to CTRL_RESET whenever no valid entry is present. Bubbles therefore never fire write/read/regWrite strobes.

Parameters:
- DATA_W, 48, width of data bundle (e.g. ALUout, rd1, rd15 concatenated).
- CTRL_W, 14, width of control bundle (op1, op2, regWrite, w, r, sb, F).
- CTRL_RESET, {CTRL_W{1'b0}}, bubble/reset value of the control bundle.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  upstream presents an entry.
- in_ready  out  1  stage can accept; registered, no combinational path from out_ready.
- in_data  in  DATA_W  upstream data bundle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts head.
- out_data  out  DATA_W  head data bundle.
- out_ctrl  out  CTRL_W  head control; CTRL_RESET when out_valid=0.
- occupancy  out  2  entries held: 0, 1 or 2.

Behaviour:
- Storage: head register (H) and skid register (S), each with a valid bit. Order is preserved: H is always older than S.
- Handshakes: accept = in_valid & in_ready; pop = out_valid & out_ready.
- Reset (reset=0, asynchronous): H.valid=0, S.valid=0, H/S data=0, H/S ctrl=CTRL_RESET.
- Outputs during and after reset: out_valid=0, out_data=0, out_ctrl=CTRL_RESET, occupancy=0, in_ready=1.
- State machine, encoded by valid bits:
  - EMPTY (0/0): accept -> ONE, H <= in. No accept -> stay.
  - ONE (H only):
    - accept & pop -> ONE, H <= in.
    - accept & !pop -> FULL, S <= in.
    - !accept & pop -> EMPTY.
    - otherwise stay.
  - FULL (H,S):
    - in_ready=0, so no accept is possible.
    - pop -> ONE, H <= S, S.valid <= 0.
    - otherwise hold.
- in_ready = !S.valid (registered state bit). Consequently in_ready=0 exactly in FULL.
- Latency: an entry accepted into EMPTY appears on out_* the next cycle.
- Throughput: 1 entry/cycle sustained while out_ready=1.
- Stall: out_ready=0 holds H stable, covering out_data, out_ctrl and out_valid. At most one further entry is absorbed into S; in_ready then drops the cycle after.
- Flush (flush=1 at clock edge):
  - Next state is EMPTY regardless of in_valid/out_ready.
  - H.ctrl and S.ctrl <= CTRL_RESET; data registers are not written (keep old values).
  - An accept in the flush cycle is discarded. Upstream is required to squash concurrently.
  - A pop in the flush cycle still counts as consumed by downstream.
- Flush and reset together: reset dominates.
- out_ctrl = out_valid ? H.ctrl : CTRL_RESET (combinational mask).
- out_data = H.data, valid or not.
- occupancy = H.valid + S.valid; value 3 is unreachable.
- No X propagation: all registers reset; no latches.

Test Plan:
- Config for all scenarios: DATA_W=16, CTRL_W=8, CTRL_RESET=0.
- Reset, then in_valid=1, in_data=16'h1234, in_ctrl=8'hA5, out_ready=1 -> next cycle out_valid=1, out_data=16'h1234, out_ctrl=8'hA5, occupancy=1.
- Streaming with out_ready=1: inputs 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 on the following consecutive cycles, in_ready constantly 1, no gaps.
- Stall absorption with out_ready=0: present 16'hAAAA then 16'hBBBB -> occupancy=2, in_ready=0, out_data=16'hAAAA held. 16'hCCCC is held off (not accepted). Then raise out_ready -> outputs AAAA, BBBB, CCCC in order, with no loss or duplication.
- Flush while FULL (ctrl 8'h11, 8'h22 held) together with in_valid=1 -> next cycle out_valid=0, out_ctrl=8'h00, occupancy=0, in_ready=1, and the flush-cycle input never appears at the output.
- Async reset mid-stream: assert reset low between clock edges while occupancy=2 -> out_valid=0 and out_ctrl=0 immediately, without waiting for a clock edge. After release, the first accepted entry appears with latency 1.
- Bubble masking: out_ready=1 with in_valid toggling 1,0,1 -> during the gap cycle out_valid=0 and out_ctrl=8'h00, even though H.ctrl still holds the previous value.
